wb_config_loader: RTL and testbench
===================================

// Module: wb_config_loader
// PURPOSE
//   Wishbone slave that receives the fabric bitstream and drives the per-column config shift chains.
//   Sits between the Caravel wishbone bus and the fpga_unidir columns.
//   Host writes a per-column bit budget (COUNT), then streams bytes (DATA).
//   Each accepted byte is serialised LSB-first into its column chain.
//   A column's chain is marked done when a DATA write arrives with that column's budget at zero.
// PARAMETERS
//   MX            7             number of fabric columns; column c is region c/4, byte lane c%4
//   NUM_REGIONS   2             config regions, ceil(MX/4); each region has 4 lanes
//   BASE_ADDR     32'h3000_0000 wishbone base address
//   REGION_STRIDE 16            byte stride between regions
// PORTS
//   wb_clk_i    in   1        single clock (fabric and bus)
//   wb_rst_i    in   1        synchronous, active-high reset
//   wbs_stb_i   in   1        strobe
//   wbs_cyc_i   in   1        cycle
//   wbs_we_i    in   1        1 = write
//   wbs_sel_i   in   4        byte select; bit j enables lane j
//   wbs_data_i  in   32       write data; byte j feeds lane j
//   wbs_addr_i  in   32       byte address
//   wbs_ack_o   out  1        one-cycle acknowledge
//   wbs_data_o  out  32       read data; valid only while ack is high on a read
//   cfg_we      out  MX       per-column shift enable (1 = shift one bit this cycle)
//   cfg_data    out  MX       per-column serial config bit
//   cfg_done    out  MX       sticky per-column done flag
// BEHAVIOUR
//   Reset values:
//     - wbs_ack_o=0, wbs_data_o=0, cfg_we=0, cfg_data=0, cfg_done=0.
//     - All COUNT bytes = 8'hFF; FSM = IDLE.
//   Decode: region r = (addr-BASE_ADDR)/REGION_STRIDE, valid for r<NUM_REGIONS.
//     Register offsets: 0x0 STATUS (RO), 0x4 COUNT (RW), 0x8 DATA (WO).
//     - Address outside [BASE, BASE+NUM_REGIONS*STRIDE): no ack, ignored.
//     - Unmapped offset inside the window: ack after 1 cycle, no effect, read data 0.
//   Lanes with c>=MX are ignored on write and read as 0.
//   FSM states: IDLE, SHIFT, ACK.
//   IDLE: accept when stb&cyc&decode-hit and ack is low.
//     - COUNT write or any read: go to ACK, so ack is high in cycle T+1 (T = accept cycle).
//     - COUNT write: for each sel lane, COUNT[c] <= byte.
//       A nonzero byte also clears cfg_done[c].
//     - DATA write: latch bytes and sel mask; go to SHIFT, k=0.
//       Lanes with COUNT==0: no shift; cfg_done[c] set at accept.
//   SHIFT (exactly 8 cycles, k=0..7):
//     - Lane c is active when sel[c] and (COUNT==FF or k<COUNT).
//     - Active lane: cfg_we[c]=1 and cfg_data[c]=byte[k]. Inactive lane: both 0.
//     - After k=7: if COUNT!=FF, COUNT <= COUNT - min(8,COUNT). 8'hFF is never decremented (unlimited).
//     - Then go to ACK. DATA write ack is high in cycle T+9.
//   ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
//     - A still-asserted stb in that cycle is not re-accepted.
//     - The next transaction can be accepted in the cycle after ACK.
//   Reads (with readback macro):
//     - STATUS = {cfg_done lanes in bits[3:0], busy in bit 31}.
//     - COUNT = the four count bytes.
//     - DATA = 0.
//   Reset mid-SHIFT: aborts immediately; partial chain contents are not restored; no ack is issued.
//   Master drops stb before ack: the transaction still completes and the ack is still emitted.
// CONFIGURATION
//   CFG_LOADER_READBACK_EN defined:
//     - STATUS and COUNT reads return live state as described under BEHAVIOUR.
//   CFG_LOADER_READBACK_EN undefined:
//     - Every read acks and returns 32'h0.
//     - STATUS/COUNT read muxes are not synthesised.
// TESTING
//   1. Reset 10 cycles, then read 0x3000_0004:
//      -> 32'hFFFF_FFFF with readback (0 without); cfg_we=0 throughout.
//   2. Write 0x3000_0008 data 32'hA5_3C_0F_81, sel=4'hF, COUNT=FF:
//      -> lane0 emits 1,0,0,0,0,0,0,1 over 8 cycles; ack at T+9; COUNT unchanged.
//   3. Write COUNT=32'h03030303, then DATA 32'hFF:
//      -> cfg_we[0] high for 3 cycles only; COUNT reads 0x00000000 afterwards.
//   4. With COUNT=0, write DATA to region 1 (0x3000_0018):
//      -> no cfg_we pulses; cfg_done[4..6]=1; cfg_done[7] stays 0 (MX=7).
//   5. Access 0x3000_0040 -> no ack in 20 cycles.
//      Access 0x3000_000C -> ack at T+1, no state change.
//   6. Assert wb_rst_i at SHIFT k=3:
//      -> next cycle cfg_we=0, ack=0, COUNT=FF, cfg_done=0.
//      A new DATA write then completes normally.

Source files
------------

// File: rtl/wb_config_loader_if.sv
// Wishbone slave bus bundle between the Caravel bus and the fabric config loader.
// Signal names follow the Caravel wbs_* naming so the wrapper maps one-to-one.
interface wb_config_loader_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_data_i;
   logic [31:0] wbs_addr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_data_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i,
      output wbs_sel_i, wbs_data_i, wbs_addr_i,
      input  wbs_ack_o, wbs_data_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
      input  wbs_sel_i, wbs_data_i, wbs_addr_i,
      output wbs_ack_o, wbs_data_o
   );
endinterface

// File: rtl/wb_config_loader.sv
// Wishbone slave that serialises bitstream bytes LSB-first into per-column config chains.
// Define CFG_LOADER_READBACK_EN to enable live STATUS/COUNT readback (else reads return 0).
module wb_config_loader #(
   parameter int          MX            = 7,
   parameter int          NUM_REGIONS   = 2,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter int          REGION_STRIDE = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wb_config_loader_if.slave wb,
   output logic [MX-1:0]     cfg_we,
   output logic [MX-1:0]     cfg_data,
   output logic [MX-1:0]     cfg_done
);
   localparam int RW   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int IW   = RW + 2;
   localparam int NCOL = 2 ** IW;

   localparam logic [31:0] WIN    = 32'(NUM_REGIONS * REGION_STRIDE);
   localparam logic [31:0] STRIDE = 32'(REGION_STRIDE);
   localparam logic [31:0] MXU    = 32'(MX);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   logic [1:0]    r_state;
   logic [2:0]    r_k;
   logic [RW-1:0] r_region;
   logic [3:0]    r_sel;
   logic [7:0]    r_byte [4];
   logic [7:0]    r_count [NCOL];
   logic [MX-1:0] r_done;
   logic [31:0]   r_rdata;

   logic [31:0]   w_off;
   logic [31:0]   w_roff;
   logic [RW-1:0] w_region;
   logic          w_hit;
   logic          w_acc;
   logic          w_is_count;
   logic          w_is_data;
   logic          w_wr_count;
   logic          w_wr_data;
   logic [31:0]   w_rdata;

   logic [IW-1:0] w_aidx [4];
   logic [IW-1:0] w_sidx [4];
   logic [3:0]    w_aval;
   logic [3:0]    w_sval;
   logic [7:0]    w_scnt [4];
   logic [3:0]    w_act;
   logic [MX-1:0] w_set;
   logic [MX-1:0] w_clr;

   assign w_off      = wb.wbs_addr_i - BASE_ADDR;
   assign w_roff     = w_off % STRIDE;
   assign w_hit      = (wb.wbs_addr_i >= BASE_ADDR) && (w_off < WIN);
   assign w_region   = RW'(w_off / STRIDE);
   assign w_is_count = (w_roff == 32'h4);
   assign w_is_data  = (w_roff == 32'h8);

   assign w_acc = (r_state == ST_IDLE) && wb.wbs_stb_i
               && wb.wbs_cyc_i && w_hit && !wb.wbs_ack_o;
   assign w_wr_count = w_acc && wb.wbs_we_i && w_is_count;
   assign w_wr_data  = w_acc && wb.wbs_we_i && w_is_data;

   // Lane j of the addressed (accept) and latched (shift) region.
   for (genvar j = 0; j < 4; j++) begin : g_lane
      assign w_aidx[j] = {w_region, 2'(j)};
      assign w_sidx[j] = {r_region, 2'(j)};
      assign w_aval[j] = 32'(w_aidx[j]) < MXU;
      assign w_sval[j] = 32'(w_sidx[j]) < MXU;
      assign w_scnt[j] = r_count[w_sidx[j]];
      assign w_act[j]  = (r_state == ST_SHIFT) && r_sel[j] && w_sval[j]
                      && ((w_scnt[j] == 8'hFF) || ({5'd0, r_k} < w_scnt[j]));
   end

   for (genvar c = 0; c < MX; c++) begin : g_col
      localparam int L = c % 4;
      logic w_here;
      logic w_asel;
      assign w_here      = (r_region == RW'(c / 4));
      assign w_asel      = (w_region == RW'(c / 4)) && wb.wbs_sel_i[L];
      assign cfg_we[c]   = w_act[L] && w_here;
      assign cfg_data[c] = w_act[L] && w_here && r_byte[L][r_k];
      assign w_set[c]    = w_wr_data && w_asel && (r_count[c] == 8'h00);
      assign w_clr[c]    = w_wr_count && w_asel
                        && (wb.wbs_data_i[8*L +: 8] != 8'h00);
   end

`ifdef CFG_LOADER_READBACK_EN
   logic          w_is_status;
   logic [7:0]    w_acnt [4];
   logic [NCOL-1:0] w_done_pad;

   assign w_is_status = (w_roff == 32'h0);
   assign w_done_pad  = NCOL'(r_done);
   for (genvar j = 0; j < 4; j++) begin : g_rb
      assign w_acnt[j] = r_count[w_aidx[j]];
   end

   always_comb begin
      w_rdata = '0;
      if (w_is_status) begin
         w_rdata[31] = (r_state != ST_IDLE);
         for (int j = 0; j < 4; j++)
            w_rdata[j] = w_aval[j] && w_done_pad[w_aidx[j]];
      end else if (w_is_count) begin
         for (int j = 0; j < 4; j++)
            w_rdata[8*j +: 8] = w_aval[j] ? w_acnt[j] : 8'h00;
      end
   end
`else
   assign w_rdata = '0;
`endif

   assign wb.wbs_ack_o  = (r_state == ST_ACK);
   assign wb.wbs_data_o = r_rdata;
   assign cfg_done      = r_done;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_region <= '0;
         r_sel    <= '0;
         r_rdata  <= '0;
         r_done   <= '0;
         for (int i = 0; i < NCOL; i++)
            r_count[i] <= 8'hFF;
         for (int j = 0; j < 4; j++)
            r_byte[j] <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  r_region <= w_region;
                  r_rdata  <= wb.wbs_we_i ? 32'h0 : w_rdata;
                  r_state  <= ST_ACK;
                  if (w_wr_count) begin
                     for (int j = 0; j < 4; j++)
                        if (wb.wbs_sel_i[j] && w_aval[j])
                           r_count[w_aidx[j]] <= wb.wbs_data_i[8*j +: 8];
                  end
                  if (w_wr_data) begin
                     r_sel   <= wb.wbs_sel_i;
                     r_k     <= '0;
                     r_state <= ST_SHIFT;
                     for (int j = 0; j < 4; j++)
                        r_byte[j] <= wb.wbs_data_i[8*j +: 8];
                  end
               end
            end
            ST_SHIFT: begin
               r_k <= r_k + 3'd1;
               if (r_k == 3'd7) begin
                  r_state <= ST_ACK;
                  // 8'hFF marks an unlimited budget and is never consumed.
                  for (int j = 0; j < 4; j++)
                     if (r_sel[j] && w_sval[j] && (w_scnt[j] != 8'hFF))
                        r_count[w_sidx[j]] <= w_scnt[j]
                           - ((w_scnt[j] > 8'd8) ? 8'd8 : w_scnt[j]);
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
               r_rdata <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
         for (int c = 0; c < MX; c++) begin
            if (w_set[c])
               r_done[c] <= 1'b1;
            else if (w_clr[c])
               r_done[c] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wb_config_loader.sv
// Bench for wb_config_loader: table-driven bus accesses with a shift-stream scoreboard.
// Builds against either setting of CFG_LOADER_READBACK_EN.
`timescale 1ns/1ps
module tb_wb_config_loader;
   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef CFG_LOADER_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] data;
      int          lat;
      logic [31:0] rd;
      logic [6:0]  done;
      bit          drop;
   } vec_t;

   typedef struct {
      logic [6:0] we;
      logic [6:0] dat;
   } shf_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] cfg_we;
   logic [6:0] cfg_data;
   logic [6:0] cfg_done;

   wb_config_loader_if bus();

   wb_config_loader dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .cfg_we   (cfg_we),
      .cfg_data (cfg_data),
      .cfg_done (cfg_done)
   );

   always #5 clk = ~clk;

   shf_t       sq[$];
   logic [7:0] m_cnt [8];
   vec_t       tv [28];
   vec_t       pv [3];
   int         checks = 0;
   int         failures = 0;

   function automatic logic [31:0] rb(input logic [31:0] x);
      return RB ? x : 32'h0;
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input bit we,
                               input logic [3:0] s, input logic [31:0] d,
                               input int lat, input logic [31:0] rd,
                               input logic [6:0] dn, input bit drop);
      vec_t v;
      v.addr = a; v.we = we; v.sel = s; v.data = d;
      v.lat = lat; v.rd = rd; v.done = dn; v.drop = drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model: pushes the expected per-cycle shift stream.
   function automatic void model(input vec_t v);
      logic [31:0] off;
      int          r;
      int          c;
      shf_t        e;
      if (v.addr < BASE || !v.we) return;
      off = v.addr - BASE;
      if (off >= 32) return;
      r = int'(off >> 4);
      if (off[3:0] == 4'h4) begin
         for (int j = 0; j < 4; j++) begin
            c = r * 4 + j;
            if (c < 7 && v.sel[j]) m_cnt[c] = v.data[8*j +: 8];
         end
      end else if (off[3:0] == 4'h8) begin
         for (int k = 0; k < 8; k++) begin
            e.we = '0;
            e.dat = '0;
            for (int j = 0; j < 4; j++) begin
               c = r * 4 + j;
               if (c < 7 && v.sel[j] && (m_cnt[c] == 8'hFF || k < int'(m_cnt[c]))) begin
                  e.we[c] = 1'b1;
                  e.dat[c] = v.data[8*j + k];
               end
            end
            sq.push_back(e);
         end
         for (int j = 0; j < 4; j++) begin
            c = r * 4 + j;
            if (c < 7 && v.sel[j] && m_cnt[c] != 8'hFF)
               m_cnt[c] = m_cnt[c] - ((m_cnt[c] > 8) ? 8'd8 : m_cnt[c]);
         end
      end
   endfunction

   task automatic access(input string id, input vec_t v);
      int          n;
      int          lat;
      bit          got;
      logic [31:0] rd;
      shf_t        e;
      bus.wbs_addr_i = v.addr;
      bus.wbs_we_i   = v.we;
      bus.wbs_sel_i  = v.sel;
      bus.wbs_data_i = v.data;
      bus.wbs_stb_i  = 1'b1;
      bus.wbs_cyc_i  = 1'b1;
      model(v);
      n = 0; lat = 0; got = 1'b0; rd = '0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (v.drop) begin
            bus.wbs_stb_i = 1'b0;
            bus.wbs_cyc_i = 1'b0;
         end
         if (sq.size() > 0) begin
            e = sq.pop_front();
            chk($sformatf("%s_we_k%0d", id, n - 1), 32'(cfg_we), 32'(e.we));
            chk($sformatf("%s_dat_k%0d", id, n - 1), 32'(cfg_data), 32'(e.dat));
         end else begin
            chk($sformatf("%s_idle_we_c%0d", id, n), 32'(cfg_we), 32'h0);
         end
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            lat = n;
            rd = bus.wbs_data_o;
         end
      end
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      chk($sformatf("%s_ack_lat", id), 32'(lat), 32'(v.lat));
      if (got) chk($sformatf("%s_rdata", id), rd, v.rd);
      chk($sformatf("%s_done", id), 32'(cfg_done), 32'(v.done));
      chk($sformatf("%s_sb_empty", id), 32'(sq.size()), 32'h0);
      sq.delete();
      @(posedge clk); #1;
      chk($sformatf("%s_ack_once", id), 32'(bus.wbs_ack_o), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wbs_stb_i  = 1'b0;
      bus.wbs_cyc_i  = 1'b0;
      bus.wbs_we_i   = 1'b0;
      bus.wbs_sel_i  = '0;
      bus.wbs_data_i = '0;
      bus.wbs_addr_i = '0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 8'hFF;

      tv[0]  = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'hFFFF_FFFF), 7'h00, 0);
      tv[1]  = mk(BASE + 32'h14, 0, 4'hF, 32'h0,          1, rb(32'h00FF_FFFF), 7'h00, 0);
      tv[2]  = mk(BASE + 32'h00, 0, 4'hF, 32'h0,          1, 32'h0,             7'h00, 0);
      tv[3]  = mk(BASE + 32'h08, 1, 4'hF, 32'hA53C_0F81,  9, 32'h0,             7'h00, 0);
      tv[4]  = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'hFFFF_FFFF), 7'h00, 0);
      tv[5]  = mk(BASE + 32'h04, 1, 4'hF, 32'h0303_0303,  1, 32'h0,             7'h00, 0);
      tv[6]  = mk(BASE + 32'h08, 1, 4'hF, 32'h0000_00FF,  9, 32'h0,             7'h00, 0);
      tv[7]  = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, 32'h0,             7'h00, 0);
      tv[8]  = mk(BASE + 32'h00, 0, 4'hF, 32'h0,          1, 32'h0,             7'h00, 0);
      tv[9]  = mk(BASE + 32'h14, 1, 4'hF, 32'h0,          1, 32'h0,             7'h00, 0);
      tv[10] = mk(BASE + 32'h18, 1, 4'hF, 32'h1234_5678,  9, 32'h0,             7'h70, 0);
      tv[11] = mk(BASE + 32'h10, 0, 4'hF, 32'h0,          1, rb(32'h0000_0007), 7'h70, 0);
      tv[12] = mk(BASE + 32'h0C, 0, 4'hF, 32'h0,          1, 32'h0,             7'h70, 0);
      tv[13] = mk(BASE + 32'h0C, 1, 4'hF, 32'hFFFF_FFFF,  1, 32'h0,             7'h70, 0);
      tv[14] = mk(BASE + 32'h04, 1, 4'h5, 32'h0A0B_0C0D,  1, 32'h0,             7'h70, 0);
      tv[15] = mk(BASE + 32'h08, 1, 4'hF, 32'hFFFF_FFFF,  9, 32'h0,             7'h7A, 0);
      tv[16] = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'h0003_0005), 7'h7A, 0);
      tv[17] = mk(BASE + 32'h04, 1, 4'h2, 32'h0000_0500,  1, 32'h0,             7'h78, 0);
      tv[18] = mk(BASE + 32'h00, 0, 4'hF, 32'h0,          1, rb(32'h0000_0008), 7'h78, 0);
      tv[19] = mk(BASE + 32'h08, 1, 4'h2, 32'h0000_AA00,  9, 32'h0,             7'h78, 1);
      tv[20] = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'h0003_0005), 7'h78, 0);
      tv[21] = mk(BASE + 32'h00, 1, 4'hF, 32'h1234_5678,  1, 32'h0,             7'h78, 0);
      tv[22] = mk(BASE + 32'h08, 0, 4'hF, 32'h0,          1, 32'h0,             7'h78, 0);
      tv[23] = mk(BASE + 32'h40, 0, 4'hF, 32'h0,          0, 32'h0,             7'h78, 0);
      tv[24] = mk(BASE + 32'h20, 1, 4'hF, 32'h0000_00FF,  0, 32'h0,             7'h78, 0);
      tv[25] = mk(32'h2FFF_FFFC, 0, 4'hF, 32'h0,          0, 32'h0,             7'h78, 0);
      tv[26] = mk(BASE + 32'h1C, 0, 4'hF, 32'h0,          1, 32'h0,             7'h78, 0);
      tv[27] = mk(BASE + 32'h14, 0, 4'hF, 32'h0,          1, 32'h0,             7'h78, 0);

      pv[0]  = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'hFFFF_FFFF), 7'h00, 0);
      pv[1]  = mk(BASE + 32'h08, 1, 4'h1, 32'h0000_00C3,  9, 32'h0,             7'h00, 0);
      pv[2]  = mk(BASE + 32'h04, 0, 4'hF, 32'h0,          1, rb(32'hFFFF_FFFF), 7'h00, 0);

      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ack",  32'(bus.wbs_ack_o), 32'h0);
      chk("rst_rd",   bus.wbs_data_o,     32'h0);
      chk("rst_we",   32'(cfg_we),        32'h0);
      chk("rst_data", 32'(cfg_data),      32'h0);
      chk("rst_done", 32'(cfg_done),      32'h0);

      for (int i = 0; i < 28; i++)
         access($sformatf("v%0d", i), tv[i]);

      // Strobe held through the ack cycle must not start a second access.
      bus.wbs_addr_i = BASE + 32'h04;
      bus.wbs_we_i   = 1'b0;
      bus.wbs_sel_i  = 4'hF;
      bus.wbs_stb_i  = 1'b1;
      bus.wbs_cyc_i  = 1'b1;
      @(posedge clk); #1;
      chk("hold_ack", 32'(bus.wbs_ack_o), 32'h1);
      chk("hold_rd",  bus.wbs_data_o, rb(32'h0003_0005));
      @(posedge clk); #1;
      chk("hold_noreacc", 32'(bus.wbs_ack_o), 32'h0);
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      @(posedge clk); #1;
      chk("hold_idle", 32'(bus.wbs_ack_o), 32'h0);

      // Reset lands while the shifter is at k=3.
      bus.wbs_addr_i = BASE + 32'h08;
      bus.wbs_we_i   = 1'b1;
      bus.wbs_sel_i  = 4'hF;
      bus.wbs_data_i = 32'h1234_5678;
      bus.wbs_stb_i  = 1'b1;
      bus.wbs_cyc_i  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         bus.wbs_stb_i = 1'b0;
         bus.wbs_cyc_i = 1'b0;
         bus.wbs_we_i  = 1'b0;
      end
      chk("rst_pre_we",   32'(cfg_we),   32'h01);
      chk("rst_pre_data", 32'(cfg_data), 32'h01);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_we",   32'(cfg_we),        32'h0);
      chk("mid_rst_ack",  32'(bus.wbs_ack_o), 32'h0);
      chk("mid_rst_done", 32'(cfg_done),      32'h0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 8'hFF;
      sq.delete();
      @(posedge clk); #1;
      chk("post_rst_ack", 32'(bus.wbs_ack_o), 32'h0);

      for (int i = 0; i < 3; i++)
         access($sformatf("p%0d", i), pv[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
